// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 message assembler and SHA256_core.
package sha256_pkg;

  typedef enum logic {
    eFill = 1'b0,
    eHold = 1'b1
  } asm_state_e;

  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 8;
  localparam int MSG_W         = 256;

  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_msg_assembler.sv
// Packs NUM_WORDS upstream words (first word most significant) into one
// 256-bit message and holds it until SHA256_core takes it.
module sha256_msg_assembler
  import sha256_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic                        clear_i,
  input  logic                        v_i,
  input  logic [WORD_W-1:0]           data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [MSG_W-1:0]            msg_o,
  input  logic                        ready_i,
  output logic [$clog2(NUM_WORDS):0]  count_o,
  output logic                        state_o
);

  localparam int CNT_W = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  // Handshake: a transfer happens in exactly the cycles where valid and ready
  // are both high; valid never depends on ready. Upstream holds data_i until
  // ready_o, and msg_o stays frozen while v_o waits for ready_i.
  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             accept, handoff;

  assign ready_o = (state_q == eFill) & en_i & ~clear_i;
  assign v_o     = (state_q == eHold) & en_i;
  assign accept  = v_i & ready_o;
  // clear_i drops a coinciding handoff as well as a coinciding word.
  assign handoff = v_o & ready_i & ~clear_i;

  assign msg_o   = msg_q;
  assign count_o = count_q;
  assign state_o = (state_q == eHold);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    msg_d   = msg_q;
    if (clear_i) begin
      state_d = eFill;
      count_d = '0;
      msg_d   = '0;
    end else if (accept) begin
      msg_d[(MSG_W - 1) - int'(count_q) * WORD_W -: WORD_W] = data_i;
      count_d = count_q + CNT_W'(1);
      if (count_q == LAST_IDX) state_d = eHold;
    end else if (handoff) begin
      state_d = eFill;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eFill;
      count_q <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      msg_q   <= msg_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_assembler.sv
// Bench for sha256_msg_assembler: vector table, directed corner sequences and
// random traffic against a word-queue reference model.
module tb_sha256_msg_assembler;

  localparam int W = 256;

  logic          clk_i = 1'b0;
  logic          reset_i, en_i, clear_i, v_i, ready_i;
  logic [31:0]   data_i;
  logic          ready_o, v_o, state_o;
  logic [W-1:0]  msg_o;
  logic [3:0]    count_o;

  sha256_msg_assembler dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (en_i),
    .clear_i (clear_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .msg_o   (msg_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .state_o (state_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard / reference model ----------------
  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [31:0]  words[$];        // words of the message being collected
  logic [W-1:0] exp_q[$];        // complete message awaiting handoff
  bit           msg_zero;        // buffer known to be all-zero
  int unsigned  n_handoff = 0;

  function automatic logic [W-1:0] pack_words(input logic [31:0] ws[$]);
    logic [W-1:0] m = '0;
    for (int i = 0; i < ws.size(); i++) m = m | ({ws[i], 224'd0} >> (32 * i));
    return m;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    words.delete();
    exp_q.delete();
    msg_zero = 1'b1;
  endtask

  // Compare DUT against the model, then advance the model for this cycle.
  task automatic model_cycle();
    bit hold, m_ready, m_v;
    hold    = (exp_q.size() != 0);
    m_ready = !hold && en_i && !clear_i;
    m_v     = hold && en_i;
    chk("ready_o", W'(ready_o), W'(m_ready));
    chk("v_o", W'(v_o), W'(m_v));
    chk("count_o", W'(count_o), hold ? W'(8) : W'(words.size()));
    chk("state_o", W'(state_o), W'(hold));
    if (hold) chk("msg_held", msg_o, exp_q[0]);
    if (msg_zero) chk("msg_zero", msg_o, '0);
    if (reset_i || clear_i) begin
      model_reset();
    end else if (v_i && m_ready) begin
      words.push_back(data_i);
      msg_zero = 1'b0;
      if (words.size() == 8) begin
        exp_q.push_back(pack_words(words));
        words.delete();
      end
    end else if (m_v && ready_i) begin
      void'(exp_q.pop_front());
      n_handoff++;
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic v,
                      input logic [31:0] d, input logic rdy, input logic rst);
    @(negedge clk_i);
    en_i = en; clear_i = clr; v_i = v; data_i = d; ready_i = rdy; reset_i = rst;
    #1;
    model_cycle();
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1, 0, 1, base + 32'(i), 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, clr, v, rdy;
    logic [31:0] d;
    logic        e_ready, e_v;
    logic [3:0]  e_cnt;
    logic        chk_msg;
  } vec_t;

  function automatic vec_t mk(logic en, logic clr, logic v, logic [31:0] d, logic rdy,
                              logic er, logic ev, logic [3:0] ec, logic cm);
    vec_t r;
    r.en = en; r.clr = clr; r.v = v; r.d = d; r.rdy = rdy;
    r.e_ready = er; r.e_v = ev; r.e_cnt = ec; r.chk_msg = cm;
    return r;
  endfunction

  localparam logic [W-1:0] MSG_1_8 =
    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

  vec_t tbl[19];

  initial begin
    int h0;
    en_i = 0; clear_i = 0; v_i = 0; data_i = '0; ready_i = 0; reset_i = 1;
    for (int k = 0; k < 8; k++) tbl[k] = mk(1, 0, 1, 32'(k + 1), 0, 1, 0, 4'(k), 0);
    for (int k = 8; k < 13; k++) tbl[k] = mk(1, 0, 1, 32'hDEADBEEF, 0, 0, 1, 4'd8, 1);
    tbl[13] = mk(0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 4'd8, 1);   // disabled: no handoff
    tbl[14] = mk(1, 0, 1, 32'hDEADBEEF, 1, 0, 1, 4'd8, 1);   // handoff
    tbl[15] = mk(1, 0, 0, 32'h0, 0, 1, 0, 4'd0, 0);
    tbl[16] = mk(1, 0, 1, 32'h000000AA, 0, 1, 0, 4'd0, 0);
    tbl[17] = mk(1, 1, 1, 32'h000000BB, 1, 0, 0, 4'd1, 0);   // clear beats word
    tbl[18] = mk(1, 0, 0, 32'h0, 0, 1, 0, 4'd0, 0);

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0; en_i = 1;
    #1;
    model_reset();
    chk("rst_ready", W'(ready_o), W'(1));
    chk("rst_v", W'(v_o), W'(0));
    chk("rst_count", W'(count_o), W'(0));
    chk("rst_msg", msg_o, '0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_ready", i), W'(ready_o), W'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_v", i), W'(v_o), W'(tbl[i].e_v));
      chk($sformatf("tbl%0d_count", i), W'(count_o), W'(tbl[i].e_cnt));
      if (tbl[i].chk_msg) chk($sformatf("tbl%0d_msg", i), msg_o, MSG_1_8);
    end
    chk("tbl_after_clear_msg", msg_o, '0);

    // three words, then clear together with a fourth
    feed(3, 32'h11110000);
    step(1, 1, 1, 32'h11110003, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0);
    chk("clr_count", W'(count_o), W'(0));
    chk("clr_msg", msg_o, '0);

    // five words, enable low four cycles, then finish
    feed(5, 32'h22220000);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h22220005, 0, 0);
    chk("en_low_count", W'(count_o), W'(5));
    feed(3, 32'h22220005);
    step(1, 0, 0, 32'h0, 0, 0);
    chk("en_resume_msg", msg_o,
        256'h22220000_22220001_22220002_22220003_22220004_22220005_22220006_22220007);
    step(1, 0, 0, 32'h0, 1, 0);

    // reset in hold together with ready_i: message discarded
    feed(8, 32'h33330000);
    h0 = n_handoff;
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 1, 0);
    chk("rst_hold_v", W'(v_o), W'(0));
    chk("rst_hold_count", W'(count_o), W'(0));
    chk("rst_hold_msg", msg_o, '0);
    chk("rst_hold_no_handoff", W'(n_handoff - h0), W'(0));

    // two messages back-to-back with ready_i tied high
    h0 = n_handoff;
    for (int i = 0; i < 18; i++) step(1, 0, 1, 32'h44440000 + 32'(i), 1, 0);
    chk("b2b_handoffs", W'(n_handoff - h0), W'(2));

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_assembler.md
SHA256_MSG_ASSEMBLER -- requirements
Module: sha256_msg_assembler

Interface
REQ-001 Parameter: WORD_W, 32, width of one input word.
REQ-002 Parameter: NUM_WORDS, 8, words per message; WORD_W*NUM_WORDS SHALL equal 256 (message width of SHA256_core msg_i).
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 en_i  input  1  enable from fsb; low freezes all state (no accept, no handoff).
REQ-006 clear_i  input  1  synchronous discard of any partial or held message.
REQ-007 v_i  input  1  data_i valid from upstream.
REQ-008 data_i  input  WORD_W  one message word.
REQ-009 ready_o  output  1  assembler accepts a word this cycle.
REQ-010 v_o  output  1  msg_o holds a complete message.
REQ-011 msg_o  output  256  assembled message, drives SHA256_core msg_i.
REQ-012 ready_i  input  1  downstream accepts msg_o (SHA256_core ready_o).
REQ-013 count_o  output  $clog2(NUM_WORDS)+1  words currently stored.

Function
REQ-014 States SHALL be eFill (collecting words) and eHold (presenting full message).
REQ-015 ready_o SHALL equal (state==eFill) & en_i & ~clear_i.
REQ-016 v_o SHALL equal (state==eHold) & en_i.
REQ-017 A word SHALL be accepted in a cycle where v_i & ready_o; no other cycle changes the buffer except clear/reset.
REQ-018 Word k accepted (k=0 first) SHALL be written to msg_o[255-k*WORD_W -: WORD_W] (first word most significant); count_o SHALL increment by 1.
REQ-019 Acceptance of word NUM_WORDS-1 SHALL move state to eHold, count_o=NUM_WORDS, v_o=1 the following cycle (1-cycle latency).
REQ-020 Handoff SHALL occur in a cycle where v_o & ready_i; next cycle state=eFill, count_o=0, ready_o=1 (if en_i); no same-cycle bypass of a new word.
REQ-021 msg_o SHALL be stable for the whole eHold interval regardless of v_i/data_i.
REQ-022 After handoff, msg_o MAY retain stale contents; only words rewritten matter once v_o rises again.
REQ-023 clear_i high SHALL, next cycle, force state=eFill, count_o=0, msg_o=0, in either state; clear_i dominates simultaneous v_i or ready_i (the word and the handoff are both dropped).
REQ-024 en_i low SHALL hold state, count_o and msg_o unchanged; ready_o and v_o read 0 during that cycle.
REQ-025 count_o SHALL never exceed NUM_WORDS and never wrap; v_i in eHold SHALL be ignored (ready_o=0).
REQ-026 v_i while ready_o=0 SHALL have no effect; upstream must hold data until ready_o.

Reset
REQ-027 reset_i high SHALL, next cycle, set state=eFill, count_o=0, msg_o=0, v_o=0; ready_o=en_i after reset releases.
REQ-028 reset_i SHALL dominate clear_i, en_i, v_i and ready_i; reset mid-fill or mid-hold discards the message with no handoff.

Structure
REQ-029 Shared package sha256_pkg SHALL hold the assembler state enum, WORD_W/NUM_WORDS defaults, the 256-bit message width constant, and the SHA-256 H0..H7 and K constants shared with SHA256_core.
REQ-030 No sub-module is required; a single always_ff for state/counter/buffer plus always_comb for next-state SHALL suffice.

Verification
REQ-031 Reset, en_i=1, feed 32'h00000001..32'h00000008 back-to-back with ready_i=0 -> v_o=1 one cycle after 8th word, msg_o=256'h00000001_00000002_..._00000008, ready_o=0, count_o=8.
REQ-032 From REQ-031, hold 5 cycles with v_i=1, data_i=32'hDEADBEEF, then ready_i=1 -> msg_o unchanged throughout, handoff in one cycle, next cycle count_o=0, v_o=0, ready_o=1.
REQ-033 Feed 3 words, assert clear_i together with v_i -> next cycle count_o=0, msg_o=0; 4th word not captured.
REQ-034 Feed 5 words, drop en_i 4 cycles with v_i=1 -> ready_o=0, count_o stays 5; resume -> remaining 3 words complete correct message.
REQ-035 In eHold assert reset_i and ready_i together -> no handoff observed, next cycle v_o=0, count_o=0, msg_o=0.
REQ-036 Two messages back-to-back with ready_i tied 1 -> each completes 1 cycle after its 8th word, handoff that cycle, second message's first word accepted the cycle after handoff; both msg_o values correct.
